// File: rtl/cru_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cru_pkg
// Brief    : Shared CRU opcode encodings, sequencer state type and address helpers.
// Revision : 1.0 - initial release
// ============================================================================
package cru_pkg;

  localparam logic [2:0]  OP_LDCR       = 3'd0;
  localparam logic [2:0]  OP_STCR       = 3'd1;
  localparam logic [2:0]  OP_SBO        = 3'd2;
  localparam logic [2:0]  OP_SBZ        = 3'd3;
  localparam logic [2:0]  OP_TB         = 3'd4;
  localparam logic [15:0] CRU_ADDR_STEP = 16'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } cru_state_t;

  function automatic logic cru_is_input(input logic [2:0] op);
    return (op == OP_STCR) || (op == OP_TB);
  endfunction

  function automatic logic cru_is_reserved(input logic [2:0] op);
    return op > OP_TB;
  endfunction

  // Single-bit ops address relative to R12 with a signed bit displacement.
  function automatic logic [15:0] cru_start_addr(input logic [2:0]  op,
                                                 input logic [15:0] base,
                                                 input logic [7:0]  disp);
    logic [15:0] w_base;
    w_base = base & 16'hfffe;
    if ((op == OP_LDCR) || (op == OP_STCR))
      return w_base;
    return w_base + {{7{disp[7]}}, disp, 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cru_master_if.sv
`default_nettype none
// ============================================================================
// Module   : cru_master_if
// Brief    : Microsequencer command/response handshake plus CRU pin bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface cru_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_base;
  logic [7:0]  cmd_disp;
  logic [3:0]  cmd_count;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        tb_bit;
  logic [15:0] ab;
  logic        cruout;
  logic        cruclk;
  logic        cruin;
  logic        cru_active;

  modport master (
    input  cmd_valid, cmd_op, cmd_base, cmd_disp, cmd_count, cmd_data, cruin,
    output cmd_ready, rsp_valid, rsp_data, tb_bit, ab, cruout, cruclk, cru_active
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_base, cmd_disp, cmd_count, cmd_data, cruin,
    input  cmd_ready, rsp_valid, rsp_data, tb_bit, ab, cruout, cruclk, cru_active
  );
endinterface
`default_nettype wire

// File: rtl/cru_master.sv
`default_nettype none
// ============================================================================
// Module   : cru_master
// Brief    : TMS9995 CRU bus initiator executing LDCR/STCR/SBO/SBZ/TB bit-serially.
// Revision : 1.0 - initial release
// ============================================================================
module cru_master
  import cru_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  cru_master_if.master  bus
);

  localparam logic [2:0] c_setup_last  = 3'(SETUP_CYCLES - 1);
  localparam logic [2:0] c_strobe_last = 3'(STROBE_CYCLES - 1);

  cru_state_t  r_state, w_state_next;
  logic [2:0]  r_op;
  logic [15:0] r_data;
  logic [15:0] r_addr;
  logic [15:0] r_rsp_data;
  logic [3:0]  r_idx;
  logic [3:0]  r_last;
  logic [2:0]  r_cnt;
  logic        r_cruclk;
  logic        r_active;
  logic        r_rsp_valid;
  logic        r_tb_bit;

  logic w_accept, w_is_input, w_last_bit, w_setup_end, w_strobe_end;
  logic w_capture, w_advance;

  assign w_accept     = bus.cmd_valid && (r_state == ST_IDLE);
  assign w_is_input   = cru_is_input(r_op);
  assign w_last_bit   = (r_idx == r_last);
  assign w_setup_end  = (r_state == ST_SETUP)  && (r_cnt == c_setup_last);
  assign w_strobe_end = (r_state == ST_STROBE) && (r_cnt == c_strobe_last);
  assign w_capture    = w_setup_end && w_is_input;
  assign w_advance    = w_capture || (r_state == ST_HOLD);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (bus.cmd_valid)
                   w_state_next = cru_is_reserved(bus.cmd_op) ? ST_DONE : ST_SETUP;
      ST_SETUP:  if (w_setup_end)
                   w_state_next = !w_is_input ? ST_STROBE
                                : (w_last_bit ? ST_DONE : ST_SETUP);
      ST_STROBE: if (w_strobe_end) w_state_next = ST_HOLD;
      ST_HOLD:   w_state_next = w_last_bit ? ST_DONE : ST_SETUP;
      ST_DONE:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Pin-level strobes are registered from the next state so cruclk cannot glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= OP_LDCR;
      r_data      <= 16'h0000;
      r_addr      <= 16'h0000;
      r_rsp_data  <= 16'h0000;
      r_idx       <= 4'd0;
      r_last      <= 4'd0;
      r_cnt       <= 3'd0;
      r_cruclk    <= 1'b1;
      r_active    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_tb_bit    <= 1'b0;
    end else begin
      r_cruclk    <= (w_state_next != ST_STROBE);
      r_active    <= (w_state_next == ST_SETUP) || (w_state_next == ST_STROBE) ||
                     (w_state_next == ST_HOLD);
      r_rsp_valid <= (w_state_next == ST_DONE);
      r_cnt       <= ((r_state == ST_SETUP || r_state == ST_STROBE) &&
                      !w_setup_end && !w_strobe_end) ? r_cnt + 3'd1 : 3'd0;

      if (w_accept) begin
        r_op       <= bus.cmd_op;
        r_data     <= bus.cmd_data;
        r_idx      <= 4'd0;
        r_rsp_data <= 16'h0000;
        // count==0 wraps to index 15, i.e. a 16-bit transfer
        r_last     <= (bus.cmd_op >= OP_SBO) ? 4'd0 : bus.cmd_count - 4'd1;
        if (!cru_is_reserved(bus.cmd_op))
          r_addr <= cru_start_addr(bus.cmd_op, bus.cmd_base, bus.cmd_disp);
      end else if (w_advance && !w_last_bit) begin
        r_idx  <= r_idx + 4'd1;
        r_addr <= r_addr + CRU_ADDR_STEP;
        r_data <= {1'b0, r_data[15:1]};
      end

      if (w_capture) begin
        r_rsp_data[r_idx] <= bus.cruin;
        if (r_op == OP_TB) r_tb_bit <= bus.cruin;
      end
    end
  end

  assign bus.cmd_ready  = (r_state == ST_IDLE);
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.tb_bit     = r_tb_bit;
  assign bus.ab         = r_addr;
  assign bus.cruout     = r_active && ((r_op == OP_LDCR) ? r_data[0] : (r_op == OP_SBO));
  assign bus.cruclk     = r_cruclk;
  assign bus.cru_active = r_active;

endmodule
`default_nettype wire

// File: tb/tb_cru_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_cru_master
// Brief    : Scoreboard bench for cru_master with a flag-register CRU responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cru_master;

  typedef struct {
    logic [15:0] data;
    logic        tb;
    logic        chk_tb;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_fall = 0;
  exp_t q1[$];
  exp_t q2[$];

  // Responder bits indexed by ab[6:1]: 47 -> 1ede, 48..63 -> 1ee0..1efe
  logic [63:0] flags = 64'h8088_8000_0000_0000;

  cru_master_if bus1();
  cru_master_if bus2();

  cru_master #(.SETUP_CYCLES(1), .STROBE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  cru_master #(.SETUP_CYCLES(2), .STROBE_CYCLES(3)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus1.cruin = flags[bus1.ab[6:1]];
  assign bus2.cruin = 1'b0;

  always @(posedge bus1.cruclk) if (!rst) flags[bus1.ab[6:1]] <= bus1.cruout;
  always @(negedge bus1.cruclk) n_fall = n_fall + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus1.rsp_valid) begin
      if (q1.size() == 0) chk("dut1_unexpected_rsp", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1_rsp_data", {16'h0, bus1.rsp_data}, {16'h0, e.data});
        chk("dut1_rsp_cycle", cyc, e.due);
        if (e.chk_tb) chk("dut1_tb_bit", {31'h0, bus1.tb_bit}, {31'h0, e.tb});
      end
    end
    if (!rst && bus2.rsp_valid) begin
      if (q2.size() == 0) chk("dut2_unexpected_rsp", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q2.pop_front();
        chk("dut2_rsp_data", {16'h0, bus2.rsp_data}, {16'h0, e.data});
        chk("dut2_rsp_cycle", cyc, e.due);
      end
    end
  end

  task automatic send1(input logic [2:0] op, input logic [15:0] base, input logic [7:0] disp,
                       input logic [3:0] cnt, input logic [15:0] data, output int acc);
    @(negedge clk);
    chk("dut1_ready_before_cmd", {31'h0, bus1.cmd_ready}, 32'd1);
    bus1.cmd_valid = 1'b1;
    bus1.cmd_op    = op;
    bus1.cmd_base  = base;
    bus1.cmd_disp  = disp;
    bus1.cmd_count = cnt;
    bus1.cmd_data  = data;
    acc = cyc;
    @(posedge clk);
    #1 bus1.cmd_valid = 1'b0;
  endtask

  task automatic expect1(input logic [15:0] data, input logic tb, input logic chk_tb, input int due);
    exp_t e;
    e.data = data; e.tb = tb; e.chk_tb = chk_tb; e.due = due;
    q1.push_back(e);
  endtask

  task automatic wait_idle1();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      #1 if (q1.size() == 0 && bus1.cmd_ready) done = 1'b1;
    end
    if (!done) chk("dut1_completion_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int acc;
    int f0;
    int low;
    bus1.cmd_valid = 1'b0; bus1.cmd_op = 3'd0; bus1.cmd_base = 16'h0;
    bus1.cmd_disp = 8'h0; bus1.cmd_count = 4'd0; bus1.cmd_data = 16'h0;
    bus2.cmd_valid = 1'b0; bus2.cmd_op = 3'd0; bus2.cmd_base = 16'h0;
    bus2.cmd_disp = 8'h0; bus2.cmd_count = 4'd0; bus2.cmd_data = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset_cmd_ready", {31'h0, bus1.cmd_ready}, 32'd1);
    chk("reset_rsp", {15'h0, bus1.rsp_valid, bus1.rsp_data}, 32'h0);
    chk("reset_tb_bit", {31'h0, bus1.tb_bit}, 32'd0);
    chk("reset_ab", {16'h0, bus1.ab}, 32'h0);
    chk("reset_pins", {29'h0, bus1.cruout, bus1.cruclk, bus1.cru_active}, 32'b010);

    // SBO 1ee0
    send1(3'd2, 16'h1ee0, 8'h00, 4'd0, 16'h0, acc);
    expect1(16'h0000, 1'b0, 1'b0, acc + 4);
    @(negedge clk);
    chk("sbo_c1_ab", {16'h0, bus1.ab}, 32'h1ee0);
    chk("sbo_c1_pins", {29'h0, bus1.cruout, bus1.cruclk, bus1.cru_active}, 32'b111);
    @(negedge clk);
    chk("sbo_c2_cruclk", {31'h0, bus1.cruclk}, 32'd0);
    @(negedge clk);
    chk("sbo_c3_hold", {30'h0, bus1.cruclk, bus1.cru_active}, 32'b11);
    wait_idle1();
    chk("sbo_flag48", {31'h0, flags[48]}, 32'd1);

    // LDCR 2 bits of 0002
    f0 = n_fall;
    send1(3'd0, 16'h1ee0, 8'h00, 4'd2, 16'h0002, acc);
    expect1(16'h0000, 1'b0, 1'b0, acc + 7);
    @(negedge clk);
    chk("ldcr_b0", {15'h0, bus1.cruout, bus1.ab}, {15'h0, 1'b0, 16'h1ee0});
    repeat (3) @(negedge clk);
    chk("ldcr_b1", {15'h0, bus1.cruout, bus1.ab}, {15'h0, 1'b1, 16'h1ee2});
    wait_idle1();
    chk("ldcr_strobes", n_fall - f0, 32'd2);
    chk("ldcr_flags", {30'h0, flags[49], flags[48]}, 32'b10);

    // STCR 4 bits -> 1010
    send1(3'd1, 16'h1ee0, 8'h00, 4'd4, 16'h0, acc);
    expect1(16'h000a, 1'b0, 1'b0, acc + 5);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("stcr_ab", {16'h0, bus1.ab}, 32'h1ee0 + 32'(2 * j));
      chk("stcr_cruclk_high", {31'h0, bus1.cruclk}, 32'd1);
    end
    wait_idle1();

    // TB at 1ede via disp -1
    send1(3'd4, 16'h1ee0, 8'hff, 4'd0, 16'h0, acc);
    expect1(16'h0001, 1'b1, 1'b1, acc + 2);
    @(negedge clk);
    chk("tb_ab", {16'h0, bus1.ab}, 32'h1ede);
    wait_idle1();
    chk("tb_bit_held", {31'h0, bus1.tb_bit}, 32'd1);

    // STCR count=0 -> 16 bits at 1ee0..1efe
    send1(3'd1, 16'h1ee0, 8'h00, 4'd0, 16'h0, acc);
    expect1(16'h808a, 1'b0, 1'b0, acc + 17);
    wait_idle1();

    // Reserved op: no bus activity, answer next cycle
    send1(3'd6, 16'h1234, 8'h00, 4'd3, 16'hffff, acc);
    expect1(16'h0000, 1'b0, 1'b0, acc + 1);
    @(negedge clk);
    chk("rsvd_inactive", {30'h0, bus1.cru_active, bus1.cruclk}, 32'b01);
    wait_idle1();

    // Slow timing: SETUP=2, STROBE=3, LDCR 1 bit
    @(negedge clk);
    bus2.cmd_valid = 1'b1; bus2.cmd_op = 3'd0; bus2.cmd_count = 4'd1;
    bus2.cmd_base = 16'h0040; bus2.cmd_data = 16'h0001;
    acc = cyc;
    @(posedge clk);
    #1 bus2.cmd_valid = 1'b0;
    begin
      exp_t e;
      e.data = 16'h0; e.tb = 1'b0; e.chk_tb = 1'b0; e.due = acc + 7;
      q2.push_back(e);
    end
    low = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (bus2.cruclk == 1'b0) low = low + 1;
    end
    chk("dut2_low_cycles", low, 32'd3);

    // Reset during STROBE of a 16-bit LDCR
    send1(3'd0, 16'h0100, 8'h00, 4'd0, 16'hffff, acc);
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_strobe", {31'h0, bus1.cruclk}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_pins", {14'h0, bus1.cruclk, bus1.cmd_ready, bus1.ab},
        {14'h0, 1'b1, 1'b1, 16'h0000});
    chk("rst_mid_quiet", {30'h0, bus1.rsp_valid, bus1.cru_active}, 32'b00);
    repeat (5) @(negedge clk);

    // SBZ 1ee2 via disp +1 after the abort
    send1(3'd3, 16'h1ee0, 8'h01, 4'd0, 16'h0, acc);
    expect1(16'h0000, 1'b0, 1'b0, acc + 4);
    @(negedge clk);
    chk("sbz_ab", {15'h0, bus1.cruout, bus1.ab}, {15'h0, 1'b0, 16'h1ee2});
    wait_idle1();
    chk("sbz_flag49", {31'h0, flags[49]}, 32'd0);

    repeat (3) @(negedge clk);
    chk("q1_drained", q1.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/cru_master.md
Name: cru_master

Overview:
- CPU-side CRU bus initiator for the TMS9995 core.
- Executes the CRU instructions LDCR, STCR, SBO, SBZ and TB. Each is a bit-serial sequence of address, cruout and cruclk strobes, with cruin sampled back.
- Drives the same CRU bus the on-chip flag register and external CRU devices respond on.
- Sits between the CPU microsequencer (command/response handshake) and the CRU address/strobe pins; the top level muxes its ab onto the address bus while cru_active=1.

Parameters:
- SETUP_CYCLES, 1, clk cycles ab/cruout are held stable before the strobe or sample (1..7).
- STROBE_CYCLES, 1, clk cycles cruclk is held low per output bit (1..7).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  master idle; command accepted when cmd_valid&cmd_ready.
- cmd_op  input  3  0=LDCR 1=STCR 2=SBO 3=SBZ 4=TB; 5-7 reserved.
- cmd_base  input  16  R12 contents; bit 0 ignored.
- cmd_disp  input  8  signed bit displacement (SBO/SBZ/TB only).
- cmd_count  input  4  bit count for LDCR/STCR; 0 means 16.
- cmd_data  input  16  LDCR source, right-justified, LSB sent first.
- rsp_valid  output  1  one-cycle pulse at completion.
- rsp_data  output  16  STCR result, right-justified; unused bits 0.
- tb_bit  output  1  TB result (copy of rsp_data[0]), held until next command.
- ab  output  16  CRU address; ab[0] always 0.
- cruout  output  1  CRU output data.
- cruclk  output  1  CRU strobe, active low (idle 1).
- cruin  input  1  CRU input data; combinational from ab at the responder.
- cru_active  output  1  high from first SETUP cycle through last bit cycle.

Behaviour:
- Reset values:
  - cmd_ready=1 (state IDLE).
  - rsp_valid=0, rsp_data=0, tb_bit=0.
  - ab=0, cruout=0, cruclk=1, cru_active=0.
- Reset mid-operation:
  - Next cycle restores all reset values.
  - Partial command is abandoned; no rsp_valid.
- States: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE, on accept:
  - Latch op, data and count (n = count==0 ? 16 : count). SBO/SBZ/TB force n=1.
  - Start address: LDCR/STCR use cmd_base & 16'hfffe; SBO/SBZ/TB use (cmd_base & 16'hfffe) + (sext(cmd_disp)<<1), mod 2^16.
  - Clear rsp_data; bit index i=0; go to SETUP.
- SETUP (SETUP_CYCLES cycles):
  - ab = current address; cruout = LDCR data[i], SBO 1, SBZ 0, STCR/TB 0; cruclk=1.
  - STCR/TB: cruin captured into rsp_data[i] on the edge ending the last SETUP cycle. Then advance; no strobe, no hold.
  - LDCR/SBO/SBZ: go to STROBE.
- STROBE (STROBE_CYCLES cycles): cruclk=0; ab and cruout unchanged.
- HOLD (1 cycle): cruclk=1; ab and cruout unchanged (responder hold time).
- Advance:
  - i==n-1 goes to DONE.
  - Otherwise i++, address += 2 (wraps mod 2^16), back to SETUP.
- DONE (1 cycle):
  - rsp_valid=1, cru_active=0, cruclk=1; TB updates tb_bit.
  - Go to IDLE, which may accept a new command the next cycle.
- Latency, accept at cycle 0:
  - Output ops finish at cycle n*(SETUP_CYCLES+STROBE_CYCLES+1)+1 (rsp_valid).
  - Input ops finish at cycle n*SETUP_CYCLES+1.
- cmd_* are ignored while cmd_ready=0.
- Reserved op: accepted, no bus activity (cru_active stays 0), rsp_valid next cycle, rsp_data=0.
- cruclk never glitches low outside STROBE; ab[0] is never 1.

Decomposition:
- Package cru_pkg: op encoding constants (OP_LDCR..OP_TB), state enum, CRU_ADDR_STEP=2.
- Single module; no sub-module is natural. The address/bit counter stays inline.

Test Plan:
1. SBO cmd_base=16'h1ee0 disp=0:
   - cycle 1: ab=1ee0, cruout=1, cruclk=1.
   - cycle 2: cruclk=0.
   - cycle 3: hold.
   - cycle 4: rsp_valid; flag-register model bit0=1.
2. LDCR base=1ee0 count=2 data=16'h0002:
   - bit 0 (cycles 1-3): ab=1ee0, cruout=0.
   - bit 1 (cycles 4-6): ab=1ee2, cruout=1.
   - rsp_valid at cycle 7; exactly 2 low strobes.
3. STCR base=1ee0 count=4, responder bits[3:0]=4'b1010:
   - ab steps 1ee0,1ee2,1ee4,1ee6 on cycles 1-4; cruclk stays 1.
   - rsp_valid at cycle 5, rsp_data=16'h000a.
4. TB base=1ee0 disp=-1 (8'hff), responder at 1ede returns 1:
   - ab=1ede; tb_bit=1 after rsp_valid; count=0 STCR on the same base returns 16 bits.
5. SETUP_CYCLES=2 STROBE_CYCLES=3, LDCR count=1: cruclk low for exactly 3 cycles; rsp_valid at cycle 7.
6. Assert rst during STROBE of a 16-bit LDCR:
   - next cycle cruclk=1, ab=0, cmd_ready=1; no rsp_valid.
   - a new SBZ then completes normally.
